// File: rtl/get_put_pump_pkg.sv
// -----------------------------------------------------------------------------
// get_put_pkg
// Shared definitions for the get_put_pump block:
//   - STATS_WIDTH : width of the optional transfer/stall statistics counters
//   - occ_state_e : FIFO occupancy state (EMPTY / PARTIAL / FULL)
//   - clog2()     : ceiling log2 used to size pointers and the occupancy count
// -----------------------------------------------------------------------------
package get_put_pkg;

  localparam int STATS_WIDTH = 32;

  // Occupancy of the pump FIFO. EMPTY and FULL directly gate the two enables.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_e;

  // Ceiling log2, minimum result 1 so a pointer always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/get_put_pump_if.sv
// -----------------------------------------------------------------------------
// get_put_pump_if
// Groups the upstream Get method, the downstream Put method and the pump's
// occupancy debug state into one bundle.
//
// Handshake semantics (BSV method style, valid/ready):
//   Upstream  : `get` is valid whenever RDY_get=1. The pump asserts EN_get in a
//               cycle to consume the word on `get` at the next rising edge.
//   Downstream: `put` carries the FIFO head. The pump asserts EN_put only when
//               RDY_put=1 and it holds data; the word is consumed at that edge.
//   Neither enable ever depends combinationally on the opposite side.
//
// Modports:
//   master : the pump (drives EN_get, put, EN_put, occ_state)
//   slave  : the environment (drives get, RDY_get, RDY_put)
// -----------------------------------------------------------------------------
import get_put_pkg::*;

interface get_put_pump_if #(
  parameter int DATA_WIDTH = 1
);

  logic [DATA_WIDTH-1:0] get;
  logic                  RDY_get;
  logic                  EN_get;
  logic [DATA_WIDTH-1:0] put;
  logic                  RDY_put;
  logic                  EN_put;
  occ_state_e            occ_state;  // debug view of the pump occupancy FSM

  modport master (
    input  get,
    input  RDY_get,
    input  RDY_put,
    output EN_get,
    output put,
    output EN_put,
    output occ_state
  );

  modport slave (
    output get,
    output RDY_get,
    output RDY_put,
    input  EN_get,
    input  put,
    input  EN_put,
    input  occ_state
  );

endinterface

// File: rtl/get_put_pump_mem.sv
// -----------------------------------------------------------------------------
// get_put_pump_mem
// DEPTH x DATA_WIDTH register file: one synchronous write port, one
// asynchronous read port. Contents are not reset; the pump masks the read
// data while empty so nothing uninitialised ever reaches its outputs.
//
// Ports:
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
// -----------------------------------------------------------------------------
module get_put_pump_mem #(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int AW         = 1
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/get_put_pump.sv
// -----------------------------------------------------------------------------
// get_put_pump
// Pulls words from an upstream BSV Get method and pushes them into a
// downstream BSV Put method through a DEPTH-entry FIFO. The FIFO breaks any
// combinational path from RDY_put to EN_get: a word captured at edge N is
// offered downstream from cycle N+1 (no bypass).
//
// Ports:
//   CLK         : clock, all state on posedge
//   RST         : synchronous reset, active-high; also gates EN_get/EN_put
//   bus         : get_put_pump_if.master (get/RDY_get/EN_get, put/RDY_put/EN_put,
//                 occ_state debug)
//   xfer_count  : words delivered via EN_put           (GET_PUT_PUMP_STATS_EN)
//   stall_count : cycles with data held and RDY_put=0  (GET_PUT_PUMP_STATS_EN)
//
// Configuration macro: GET_PUT_PUMP_STATS_EN adds the two 32-bit wrapping
// statistics counters. Without it the ports and counters do not exist and the
// datapath is unchanged.
//
// DEPTH must be a power of two (>= 2) so pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module get_put_pump
  import get_put_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  get_put_pump_if.master         bus
`ifdef GET_PUT_PUMP_STATS_EN
  ,
  output logic [STATS_WIDTH-1:0] xfer_count,
  output logic [STATS_WIDTH-1:0] stall_count
`endif
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  occ_state_e            state_q, state_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  en_get;
  logic                  en_put;
  logic [DATA_WIDTH-1:0] head;

  // Enables depend only on registered flags and the local ready inputs; RST
  // forces both low so nothing is consumed in a reset cycle.
  assign en_get = ~RST & bus.RDY_get & ~full_q;
  assign en_put = ~RST & bus.RDY_put & ~empty_q;

  get_put_pump_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk_i   (CLK),
    .we_i    (en_get),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.get),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  // Next-state: pointers, occupancy count and the EMPTY/PARTIAL/FULL FSM.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    empty_d  = empty_q;
    full_d   = full_q;

    if (en_get) wr_ptr_d = wr_ptr_q + PW'(1);
    if (en_put) rd_ptr_d = rd_ptr_q + PW'(1);

    // Simultaneous get and put (PARTIAL only) leaves the count unchanged.
    count_d = count_q + CW'(en_get) - CW'(en_put);

    if (count_d == '0) begin
      state_d = OCC_EMPTY;
    end else if (count_d == CW'(DEPTH)) begin
      state_d = OCC_FULL;
    end else begin
      state_d = OCC_PARTIAL;
    end

    empty_d = (state_d == OCC_EMPTY);
    full_d  = (state_d == OCC_FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= OCC_EMPTY;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
    end
  end

  assign bus.EN_get    = en_get;
  assign bus.EN_put    = en_put;
  // Mask the head while empty: stale or never-written entries stay invisible.
  assign bus.put       = empty_q ? '0 : head;
  assign bus.occ_state = state_q;

`ifdef GET_PUT_PUMP_STATS_EN
  logic [STATS_WIDTH-1:0] xfer_q;
  logic [STATS_WIDTH-1:0] stall_q;

  // Counters wrap naturally at 2^STATS_WIDTH.
  always_ff @(posedge CLK) begin
    if (RST) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      if (en_put)                   xfer_q  <= xfer_q + STATS_WIDTH'(1);
      if (~empty_q & ~bus.RDY_put)  stall_q <= stall_q + STATS_WIDTH'(1);
    end
  end

  assign xfer_count  = xfer_q;
  assign stall_count = stall_q;
`else
  // Statistics disabled: no counter state is built.
`endif

endmodule
